// File: rtl/ide_strobe_filter_if.sv
// ---------------------------------------------------------------------------
// | ide_strobe_filter_if : sampled IDE host-control pins and bus-cycle events |
// | Revision: 1.0                                                             |
// ---------------------------------------------------------------------------
`default_nettype none

interface ide_strobe_filter_if;
  logic       dior_n_in;
  logic       diow_n_in;
  logic [1:0] cs_n_in;
  logic [2:0] da_in;
  logic       hreset_n_in;
  logic       rd_start;
  logic       rd_end;
  logic       wr_start;
  logic       wr_end;
  logic       reg_cs1;
  logic [2:0] reg_addr;
  logic       busy;
  logic       host_reset;
  logic       protocol_err;

  modport master (
    output dior_n_in, diow_n_in, cs_n_in, da_in, hreset_n_in,
    input  rd_start, rd_end, wr_start, wr_end, reg_cs1, reg_addr,
           busy, host_reset, protocol_err
  );

  modport slave (
    input  dior_n_in, diow_n_in, cs_n_in, da_in, hreset_n_in,
    output rd_start, rd_end, wr_start, wr_end, reg_cs1, reg_addr,
           busy, host_reset, protocol_err
  );
endinterface

`default_nettype wire

// File: rtl/ide_strobe_filter.sv
// ---------------------------------------------------------------------------
// | ide_strobe_filter : glitch-filters IDE strobes/reset, emits cycle events  |
// | Revision: 1.0                                                             |
// ---------------------------------------------------------------------------
`default_nettype none

module ide_strobe_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  ide_strobe_filter_if.slave  bus
);

  localparam logic [2:0] C_CNT_LAST = 3'(FILTER_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_WRITE  = 2'd2,
    ST_IGNORE = 2'd3
  } state_t;

  // Bit 0 = DIOR-, bit 1 = DIOW-, bit 2 = host RESET-; all idle high.
  logic [2:0] raw;
  logic [2:0] filt_q;
  logic [2:0] filt_d;

  assign raw = {bus.hreset_n_in, bus.diow_n_in, bus.dior_n_in};

  for (genvar i = 0; i < 3; i++) begin : g_filt
    logic       val_q;
    logic       val_d;
    logic [2:0] cnt_q;
    logic [2:0] cnt_d;

    always_comb begin
      val_d = val_q;
      cnt_d = 3'd0;
      if (raw[i] != val_q) begin
        if (cnt_q == C_CNT_LAST) begin
          val_d = raw[i];
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        val_q <= 1'b1;
        cnt_q <= 3'd0;
      end else begin
        val_q <= val_d;
        cnt_q <= cnt_d;
      end
    end

    assign filt_q[i] = val_q;
    assign filt_d[i] = val_d;
  end

  logic dior_fall;
  logic dior_rise;
  logic diow_fall;
  logic diow_rise;
  logic cs_valid;

  // Edges are taken against the next filtered value so events land on the
  // same clock edge as the filtered transition.
  assign dior_fall = filt_q[0] & ~filt_d[0];
  assign dior_rise = ~filt_q[0] & filt_d[0];
  assign diow_fall = filt_q[1] & ~filt_d[1];
  assign diow_rise = ~filt_q[1] & filt_d[1];
  assign cs_valid  = ^bus.cs_n_in;

  state_t     state_q, state_d;
  logic       rd_start_q, rd_start_d;
  logic       rd_end_q, rd_end_d;
  logic       wr_start_q, wr_start_d;
  logic       wr_end_q, wr_end_d;
  logic       err_q, err_d;
  logic       busy_q, busy_d;
  logic       host_reset_q, host_reset_d;
  logic       reg_cs1_q, reg_cs1_d;
  logic [2:0] reg_addr_q, reg_addr_d;

  always_comb begin
    state_d      = state_q;
    rd_start_d   = 1'b0;
    rd_end_d     = 1'b0;
    wr_start_d   = 1'b0;
    wr_end_d     = 1'b0;
    err_d        = 1'b0;
    reg_cs1_d    = reg_cs1_q;
    reg_addr_d   = reg_addr_q;
    host_reset_d = ~filt_d[2];

    if (host_reset_d) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (dior_fall && diow_fall) begin
            err_d   = 1'b1;
            state_d = ST_IGNORE;
          end else if (dior_fall && filt_d[1]) begin
            if (cs_valid) begin
              state_d    = ST_READ;
              rd_start_d = 1'b1;
              reg_cs1_d  = ~bus.cs_n_in[1];
              reg_addr_d = bus.da_in;
            end else begin
              state_d = ST_IGNORE;
            end
          end else if (diow_fall && filt_d[0]) begin
            if (cs_valid) begin
              state_d    = ST_WRITE;
              wr_start_d = 1'b1;
              reg_cs1_d  = ~bus.cs_n_in[1];
              reg_addr_d = bus.da_in;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        ST_READ: begin
          if (dior_rise) begin
            rd_end_d = 1'b1;
            state_d  = ST_IDLE;
          end
          if (diow_fall) begin
            err_d = 1'b1;
          end
        end
        ST_WRITE: begin
          if (diow_rise) begin
            wr_end_d = 1'b1;
            state_d  = ST_IDLE;
          end
          if (dior_fall) begin
            err_d = 1'b1;
          end
        end
        ST_IGNORE: begin
          if (filt_d[0] && filt_d[1]) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d == ST_READ) || (state_d == ST_WRITE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rd_start_q   <= 1'b0;
      rd_end_q     <= 1'b0;
      wr_start_q   <= 1'b0;
      wr_end_q     <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      host_reset_q <= 1'b0;
      reg_cs1_q    <= 1'b0;
      reg_addr_q   <= 3'd0;
    end else begin
      state_q      <= state_d;
      rd_start_q   <= rd_start_d;
      rd_end_q     <= rd_end_d;
      wr_start_q   <= wr_start_d;
      wr_end_q     <= wr_end_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      host_reset_q <= host_reset_d;
      reg_cs1_q    <= reg_cs1_d;
      reg_addr_q   <= reg_addr_d;
    end
  end

  assign bus.rd_start     = rd_start_q;
  assign bus.rd_end       = rd_end_q;
  assign bus.wr_start     = wr_start_q;
  assign bus.wr_end       = wr_end_q;
  assign bus.protocol_err = err_q;
  assign bus.busy         = busy_q;
  assign bus.host_reset   = host_reset_q;
  assign bus.reg_cs1      = reg_cs1_q;
  assign bus.reg_addr     = reg_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_ide_strobe_filter.sv
// ---------------------------------------------------------------------------
// | tb_ide_strobe_filter : directed bench with a cycle model of the filter   |
// | Revision: 1.0                                                             |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ide_strobe_filter;

  localparam int L = 3;
  localparam logic [6:0] MASK = 7'((1 << L) - 1);

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ide_strobe_filter_if bus ();

  ide_strobe_filter #(.FILTER_LEN(L)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a filtered line flips once its last L raw samples all disagree
  // with it; protocol modes 0 idle, 1 read, 2 write, 3 ignore.
  typedef struct packed {
    logic [2:0][6:0] h;
    logic [2:0]      f;
    logic [1:0]      mode;
    logic            rd_s, rd_e, wr_s, wr_e, err, busy, hr, cs1;
    logic [2:0]      addr;
  } model_t;

  function automatic model_t model_reset();
    model_t m;
    m      = '0;
    m.h    = {3{7'h7f}};
    m.f    = 3'b111;
    return m;
  endfunction

  function automatic model_t model_step(input model_t m, input logic [2:0] raw,
                                        input logic [1:0] cs, input logic [2:0] da);
    model_t     n;
    logic [2:0] fall, rise;
    logic       sel_ok;
    n = m;
    for (int i = 0; i < 3; i++) begin
      n.h[i] = {m.h[i][5:0], raw[i]};
      if ((n.h[i] & MASK) == (m.f[i] ? 7'd0 : MASK)) n.f[i] = ~m.f[i];
    end
    fall   = m.f & ~n.f;
    rise   = ~m.f & n.f;
    sel_ok = (cs == 2'b10) || (cs == 2'b01);
    {n.rd_s, n.rd_e, n.wr_s, n.wr_e, n.err} = '0;
    n.hr = ~n.f[2];
    if (n.hr) begin
      n.mode = 2'd0;
    end else if (m.mode == 2'd0) begin
      if (fall[0] && fall[1]) begin
        n.err = 1'b1; n.mode = 2'd3;
      end else if ((fall[0] && n.f[1]) || (fall[1] && n.f[0])) begin
        if (!sel_ok) n.mode = 2'd3;
        else begin
          n.mode = fall[0] ? 2'd1 : 2'd2;
          n.rd_s = fall[0];
          n.wr_s = fall[1];
          n.cs1  = (cs == 2'b01);
          n.addr = da;
        end
      end
    end else if (m.mode == 2'd1) begin
      if (rise[0]) begin n.rd_e = 1'b1; n.mode = 2'd0; end
      if (fall[1]) n.err = 1'b1;
    end else if (m.mode == 2'd2) begin
      if (rise[1]) begin n.wr_e = 1'b1; n.mode = 2'd0; end
      if (fall[0]) n.err = 1'b1;
    end else begin
      if (n.f[0] && n.f[1]) n.mode = 2'd0;
    end
    n.busy = (n.mode == 2'd1) || (n.mode == 2'd2);
    return n;
  endfunction

  model_t mdl;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mdl <= model_reset();
    else mdl <= model_step(mdl, {bus.hreset_n_in, bus.diow_n_in, bus.dior_n_in},
                           bus.cs_n_in, bus.da_in);
  end

  always @(negedge clk) begin
    chk("rd_start",     int'(bus.rd_start),     int'(mdl.rd_s));
    chk("rd_end",       int'(bus.rd_end),       int'(mdl.rd_e));
    chk("wr_start",     int'(bus.wr_start),     int'(mdl.wr_s));
    chk("wr_end",       int'(bus.wr_end),       int'(mdl.wr_e));
    chk("protocol_err", int'(bus.protocol_err), int'(mdl.err));
    chk("busy",         int'(bus.busy),         int'(mdl.busy));
    chk("host_reset",   int'(bus.host_reset),   int'(mdl.hr));
    chk("reg_cs1",      int'(bus.reg_cs1),      int'(mdl.cs1));
    chk("reg_addr",     int'(bus.reg_addr),     int'(mdl.addr));
  end

  // Event tallies for the hand-computed expectations.
  int cyc_idx, n_rs, n_re, n_ws, n_we, n_err, n_busy, n_hr;
  int t_rs, t_re, a_rs, a_ws, a_we, c_rs, c_ws;

  always @(negedge clk) begin
    cyc_idx++;
    if (bus.rd_start)     begin n_rs++; t_rs = cyc_idx; a_rs = int'(bus.reg_addr); c_rs = int'(bus.reg_cs1); end
    if (bus.rd_end)       begin n_re++; t_re = cyc_idx; end
    if (bus.wr_start)     begin n_ws++; a_ws = int'(bus.reg_addr); c_ws = int'(bus.reg_cs1); end
    if (bus.wr_end)       begin n_we++; a_we = int'(bus.reg_addr); end
    if (bus.protocol_err) n_err++;
    if (bus.busy)         n_busy++;
    if (bus.host_reset)   n_hr++;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  int t0, b0, rs0, re0, ws0, we0, e0, h0;

  task automatic snap();
    b0 = n_busy; rs0 = n_rs; re0 = n_re; ws0 = n_ws; we0 = n_we; e0 = n_err; h0 = n_hr;
  endtask

  initial begin
    checks = 0; errors = 0; cyc_idx = 0;
    rst_n = 1'b0;
    bus.dior_n_in = 1'b1; bus.diow_n_in = 1'b1; bus.cs_n_in = 2'b11;
    bus.da_in = 3'd0; bus.hreset_n_in = 1'b1;
    cyc(2);
    chk("rst busy", int'(bus.busy), 0);
    chk("rst host_reset", int'(bus.host_reset), 0);
    chk("rst reg_addr", int'(bus.reg_addr), 0);
    chk("rst rd_start", int'(bus.rd_start), 0);
    rst_n = 1'b1;
    cyc(2);

    // Read, CS0, DA=5, 8-cycle strobe.
    bus.cs_n_in = 2'b10; bus.da_in = 3'd5;
    snap();
    bus.dior_n_in = 1'b0; t0 = cyc_idx;
    cyc(8);
    chk("rd_start latency", t_rs - t0, 3);
    chk("rd reg_cs1", c_rs, 0);
    chk("rd reg_addr", a_rs, 5);
    bus.dior_n_in = 1'b1; t0 = cyc_idx;
    cyc(6);
    chk("rd_end latency", t_re - t0, 3);
    chk("rd busy cycles", n_busy - b0, 8);
    chk("rd pulse count", (n_rs - rs0) * 10 + (n_re - re0), 11);

    // Write glitches: 2 samples rejected, 3 accepted.
    snap();
    bus.diow_n_in = 1'b0; cyc(2); bus.diow_n_in = 1'b1; cyc(5);
    chk("glitch2 wr_start", n_ws - ws0, 0);
    chk("glitch2 busy", n_busy - b0, 0);
    bus.diow_n_in = 1'b0; cyc(3); bus.diow_n_in = 1'b1; cyc(5);
    chk("glitch3 wr pulses", (n_ws - ws0) * 10 + (n_we - we0), 11);

    // CS1 write, DA changes mid-strobe.
    bus.cs_n_in = 2'b01; bus.da_in = 3'd6;
    bus.diow_n_in = 1'b0; cyc(4);
    bus.da_in = 3'd0; cyc(4);
    bus.diow_n_in = 1'b1; cyc(5);
    chk("wr reg_cs1", c_ws, 1);
    chk("wr reg_addr", a_ws, 6);
    chk("wr_end reg_addr", a_we, 6);

    // Simultaneous strobes, then a normal read.
    bus.cs_n_in = 2'b10; bus.da_in = 3'd3;
    snap();
    bus.dior_n_in = 1'b0; bus.diow_n_in = 1'b0; cyc(6);
    chk("overlap err count", n_err - e0, 1);
    chk("overlap starts", (n_rs - rs0) + (n_ws - ws0), 0);
    bus.dior_n_in = 1'b1; bus.diow_n_in = 1'b1; cyc(6);
    bus.dior_n_in = 1'b0; cyc(4); bus.dior_n_in = 1'b1; cyc(5);
    chk("post-overlap read", (n_rs - rs0) * 10 + (n_re - re0), 11);
    chk("post-overlap addr", a_rs, 3);

    // Neither CS asserted.
    bus.cs_n_in = 2'b11;
    snap();
    bus.dior_n_in = 1'b0; cyc(5); bus.dior_n_in = 1'b1; cyc(5);
    chk("no-cs pulses", (n_rs - rs0) + (n_re - re0) + (n_err - e0), 0);

    // Host reset during a write.
    bus.cs_n_in = 2'b10; bus.da_in = 3'd2;
    snap();
    bus.diow_n_in = 1'b0; cyc(5);
    bus.hreset_n_in = 1'b0; cyc(3); bus.hreset_n_in = 1'b1; cyc(1);
    chk("hreset busy", int'(bus.busy), 0);
    cyc(2);
    bus.diow_n_in = 1'b1; cyc(6);
    chk("hreset cycles", n_hr - h0, 3);
    chk("hreset wr_start", n_ws - ws0, 1);
    chk("hreset no wr_end", n_we - we0, 0);

    // Asynchronous reset mid-read.
    bus.da_in = 3'd1;
    snap();
    bus.dior_n_in = 1'b0; cyc(5);
    chk("pre-rst busy", int'(bus.busy), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async busy", int'(bus.busy), 0);
    chk("async reg_addr", int'(bus.reg_addr), 0);
    chk("async rd_end", int'(bus.rd_end), 0);
    cyc(1);
    bus.dior_n_in = 1'b1; rst_n = 1'b1;
    cyc(6);
    chk("async no rd_end", n_re - re0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
